aw_w_order_router: RTL

Write-data (W) channel stage directly downstream of the AW write controller in the AXI4 interconnect. Records every accepted AW transaction (granted master, selected slave, burst length) in an in-order queue, then routes W beats from that master to that slave one burst at a time. Generates WLAST from its own beat counter and reports queue-full and completed-burst status back to the write controller.

---
 rtl/aw_w_order_router.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/aw_w_order_router.sv
// aw_w_order_router: W-channel stage behind the AW write controller.
// Each accepted AW transfer is recorded as {master, slave, len} in an in-order
// queue. W beats are then routed from that master to that slave one burst at a
// time, and WLAST is generated from a local beat counter.
// Optional feature: define WLAST_CHECK_EN to compare the master's WLAST with the
// locally generated one and raise a sticky wlast_err on any disagreement.
// Handshake: a W beat transfers on a rising edge where m_wvalid[s] and
// m_wready[s] are both high. Valid never depends on ready; s_wready[act_m]
// simply mirrors m_wready[act_s] during BURST.
module aw_w_order_router #(
    parameter int NUM_MASTERS = 2,
    parameter int NUM_SLAVES  = 2,
    parameter int DATA_W      = 32,
    parameter int LEN_W       = 8,
    parameter int DEPTH       = 4,
    parameter int MID_W       = $clog2(NUM_MASTERS),
    parameter int ID_W        = $clog2(NUM_SLAVES)
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic                                    aw_push,
    input  logic [MID_W-1:0]                        aw_master,
    input  logic [ID_W-1:0]                         aw_slave,
    input  logic [LEN_W-1:0]                        aw_len,
    output logic                                    Queue_Is_Full,
    input  logic [NUM_MASTERS-1:0][DATA_W-1:0]      s_wdata,
    input  logic [NUM_MASTERS-1:0][DATA_W/8-1:0]    s_wstrb,
    input  logic [NUM_MASTERS-1:0]                  s_wlast,
    input  logic [NUM_MASTERS-1:0]                  s_wvalid,
    output logic [NUM_MASTERS-1:0]                  s_wready,
    output logic [NUM_SLAVES-1:0][DATA_W-1:0]       m_wdata,
    output logic [NUM_SLAVES-1:0][DATA_W/8-1:0]     m_wstrb,
    output logic [NUM_SLAVES-1:0]                   m_wlast,
    output logic [NUM_SLAVES-1:0]                   m_wvalid,
    input  logic [NUM_SLAVES-1:0]                   m_wready,
    output logic [3:0]                              Num_Of_Compl_Bursts,
    output logic                                    busy,
    output logic                                    wlast_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

    state_t state_q, state_d;

    logic [MID_W-1:0] q_master [DEPTH];
    logic [ID_W-1:0]  q_slave  [DEPTH];
    logic [LEN_W-1:0] q_len    [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;

    logic [MID_W-1:0] act_m;
    logic [ID_W-1:0]  act_s;
    logic [LEN_W-1:0] act_len;
    logic [LEN_W-1:0] beat;

    logic q_empty, q_full, push_ok, pop, beat_hs, last_hs;

    assign q_empty = (count == '0);
    assign q_full  = (count == CNT_W'(DEPTH));
    // A push while full is dropped even if a pop happens in the same cycle.
    assign push_ok = aw_push & ~q_full;
    assign beat_hs = (state_q == BURST) & s_wvalid[act_m] & m_wready[act_s];
    assign last_hs = beat_hs & (beat == act_len);
    // Pop from IDLE, or straight into the next burst on the final beat (no bubble).
    assign pop     = ~q_empty & ((state_q == IDLE) | last_hs);

    assign Queue_Is_Full = q_full;
    assign busy          = (state_q == BURST);

    // Queue storage: written only on an accepted push, contents need no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            q_master[wr_ptr] <= aw_master;
            q_slave[wr_ptr]  <= aw_slave;
            q_len[wr_ptr]    <= aw_len;
        end
    end

    // Queue pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (!q_empty) state_d = BURST;
            BURST:   if (last_hs && q_empty) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Active burst registers: loaded on pop, beat counts handshakes.
    always_ff @(posedge clk) begin
        if (reset) begin
            act_m   <= '0;
            act_s   <= '0;
            act_len <= '0;
            beat    <= '0;
        end else if (pop) begin
            act_m   <= q_master[rd_ptr];
            act_s   <= q_slave[rd_ptr];
            act_len <= q_len[rd_ptr];
            beat    <= '0;
        end else if (beat_hs) begin
            beat    <= beat + LEN_W'(1);
        end
    end

    // Completed-burst counter, wraps modulo 16.
    always_ff @(posedge clk) begin
        if (reset)        Num_Of_Compl_Bursts <= '0;
        else if (last_hs) Num_Of_Compl_Bursts <= Num_Of_Compl_Bursts + 4'd1;
    end

`ifdef WLAST_CHECK_EN
    // Sticky flag: master WLAST disagrees with the locally generated WLAST.
    always_ff @(posedge clk) begin
        if (reset)
            wlast_err <= 1'b0;
        else if (beat_hs && (s_wlast[act_m] != (beat == act_len)))
            wlast_err <= 1'b1;
    end
`else
    logic unused_wlast;
    assign unused_wlast = ^s_wlast;
    assign wlast_err    = 1'b0;
`endif

    // Output routing: only the active master/slave pair is connected in BURST.
    always_comb begin
        s_wready = '0;
        m_wvalid = '0;
        m_wlast  = '0;
        m_wdata  = '0;
        m_wstrb  = '0;
        if (state_q == BURST) begin
            m_wvalid[act_s] = s_wvalid[act_m];
            s_wready[act_m] = m_wready[act_s];
            m_wdata[act_s]  = s_wdata[act_m];
            m_wstrb[act_s]  = s_wstrb[act_m];
            m_wlast[act_s]  = (beat == act_len);
        end
    end

endmodule
